seq_gen: RTL

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// seq_gen: serial pattern burst generator.
//
// A shadow register holds a PAT_W-bit pattern (reset value PAT_INIT). A start
// pulse in IDLE latches the pattern, rep_cnt and gap into working registers.
// The block then transmits the pattern MSB first, rep_cnt+1 times, with gap
// idle cycles between repetitions. A one-cycle done pulse follows the last bit.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request a burst; accepted only in IDLE
//   load_en   write load_pat into the shadow pattern register (any state)
//   load_pat  new pattern, MSB transmitted first
//   rep_cnt   burst length minus one
//   gap       idle cycles between repetitions
//   abort     (only with SEQ_GEN_ABORT_EN) cancel the burst in SEND/GAP
//   data_out  serial data bit (registered)
//   data_vld  data_out carries a pattern bit (registered)
//   busy      burst in progress (registered)
//   done      single-cycle end-of-burst pulse (registered)
//
// Build option: define SEQ_GEN_ABORT_EN to add the abort input.
module seq_gen #(
  parameter int unsigned            PAT_W    = 6,
  parameter logic [PAT_W-1:0]       PAT_INIT = 6'b101001,
  parameter int unsigned            REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_en,
  input  logic [PAT_W-1:0] load_pat,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [3:0]       gap,
`ifdef SEQ_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             data_out,
  output logic             data_vld,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CntW    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CntW-1:0]  LastBit = CntW'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   shadow_q, shadow_d;
  logic [PAT_W-1:0]   work_q, work_d;    // pattern latched for this burst
  logic [PAT_W-1:0]   shift_q, shift_d;  // MSB is the bit currently on data_out
  logic [CntW-1:0]    bit_q, bit_d;      // bits still to send after the current one
  logic [REP_W-1:0]   rep_q, rep_d;      // repetitions still to start
  logic [3:0]         gap_len_q, gap_len_d;
  logic [3:0]         gap_q, gap_d;      // gap cycles remaining after the current one
  logic               data_out_q, data_out_d;
  logic               data_vld_q, data_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_req;

`ifdef SEQ_GEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    // A load coinciding with an accepted start is visible to that start.
    shadow_d   = load_en ? load_pat : shadow_q;
    work_d     = work_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    rep_d      = rep_q;
    gap_len_d  = gap_len_q;
    gap_d      = gap_q;
    data_out_d = 1'b0;
    data_vld_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSend;
          work_d     = shadow_d;
          shift_d    = shadow_d;
          bit_d      = LastBit;
          rep_d      = rep_cnt;
          gap_len_d  = gap;
          data_out_d = shadow_d[PAT_W-1];
          data_vld_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      StSend: begin
        if (abort_req) begin
          state_d = StIdle;
        end else if (bit_q != '0) begin
          shift_d    = shift_q << 1;
          bit_d      = bit_q - 1'b1;
          data_out_d = shift_d[PAT_W-1];
          data_vld_d = 1'b1;
          busy_d     = 1'b1;
        end else if (rep_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - 1'b1;
          if (gap_len_q == 4'd0) begin
            // Back-to-back repetition, no bubble.
            shift_d    = work_q;
            bit_d      = LastBit;
            data_out_d = work_q[PAT_W-1];
            data_vld_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = gap_len_q - 4'd1;
            busy_d  = 1'b1;
          end
        end
      end

      StGap: begin
        if (abort_req) begin
          state_d = StIdle;
        end else if (gap_q == 4'd0) begin
          state_d    = StSend;
          shift_d    = work_q;
          bit_d      = LastBit;
          data_out_d = work_q[PAT_W-1];
          data_vld_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          gap_d  = gap_q - 4'd1;
          busy_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shadow_q   <= PAT_INIT;
      work_q     <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      rep_q      <= '0;
      gap_len_q  <= '0;
      gap_q      <= '0;
      data_out_q <= 1'b0;
      data_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      work_q     <= work_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      rep_q      <= rep_d;
      gap_len_q  <= gap_len_d;
      gap_q      <= gap_d;
      data_out_q <= data_out_d;
      data_vld_q <= data_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign data_vld = data_vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
